// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input in clk cycles,
// with saturation timeout and stuck-level reporting.
module pwm_capture #(
    parameter int pwm_width   = 16,
    parameter int sync_stages = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pwm_in,
    output logic [pwm_width-1:0] period,
    output logic [pwm_width-1:0] high_time,
    output logic                 valid,
    output logic                 timeout,
    output logic                 stuck_high
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
    state_t state, state_nxt;
    logic [sync_stages-1:0] sync_q;
    logic s, s_d, rise, fall, sat;
    logic [pwm_width-1:0] cnt, cnt_nxt, cnt_inc, hi_lat, hi_nxt, period_nxt, high_nxt;
    logic valid_nxt, timeout_nxt, stuck_nxt;

    assign s       = sync_q[sync_stages-1];
    assign rise    = s & ~s_d;
    assign fall    = ~s & s_d;
    assign sat     = &cnt;
    // A fall seen at saturation must not wrap the counter; LOW then times out next cycle.
    assign cnt_inc = sat ? cnt : cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            s_d        <= 1'b0;
            state      <= IDLE;
            cnt        <= '0;
            hi_lat     <= '0;
            period     <= '0;
            high_time  <= '0;
            valid      <= 1'b0;
            timeout    <= 1'b0;
            stuck_high <= 1'b0;
        end else begin
            sync_q     <= {sync_q[sync_stages-2:0], pwm_in};
            s_d        <= s;
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            hi_lat     <= hi_nxt;
            period     <= period_nxt;
            high_time  <= high_nxt;
            valid      <= valid_nxt;
            timeout    <= timeout_nxt;
            stuck_high <= stuck_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        hi_nxt      = hi_lat;
        period_nxt  = period;
        high_nxt    = high_time;
        valid_nxt   = 1'b0;
        timeout_nxt = 1'b0;
        stuck_nxt   = stuck_high;
        case (state)
            IDLE: if (rise) begin
                state_nxt = HIGH;
                cnt_nxt   = 1;
            end
            HIGH: if (fall) begin
                hi_nxt    = cnt;
                cnt_nxt   = cnt_inc;
                state_nxt = LOW;
            end else if (sat) begin
                timeout_nxt = 1'b1;
                stuck_nxt   = s;
                state_nxt   = IDLE;
            end else cnt_nxt = cnt_inc;
            LOW: if (rise) begin
                period_nxt = cnt;
                high_nxt   = hi_lat;
                valid_nxt  = 1'b1;
                cnt_nxt    = 1;
                state_nxt  = HIGH;
            end else if (sat) begin
                timeout_nxt = 1'b1;
                stuck_nxt   = s;
                state_nxt   = IDLE;
            end else cnt_nxt = cnt_inc;
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: drives PWM pulse trains and checks valid/timeout events against a pulse-level model.
module tb_pwm_capture;
    localparam int W    = 8;
    localparam int SYNC = 2;
    localparam int LAT  = SYNC + 1;
    localparam int MAXC = (1 << W) - 1;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] cyc;
        logic [7:0]  a;
        logic [7:0]  b;
    } ev_t;

    logic clk = 1'b0, rst_n = 1'b0, pwm_in = 1'b0;
    logic [W-1:0] period, high_time;
    logic valid, timeout, stuck_high;
    int cyc = 0, total = 0, bad = 0;
    ev_t exp_q[$], obs_q[$];
    logic pending = 1'b0, ms = 1'b0;
    logic [7:0] mp = '0, mh = '0;
    int prev_p = 0, prev_h = 0;

    pwm_capture #(.pwm_width(W), .sync_stages(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .period(period),
        .high_time(high_time), .valid(valid), .timeout(timeout), .stuck_high(stuck_high)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(int kind, int c, int a, int b);
        ev_t e;
        e.kind = 2'(kind);
        e.cyc  = 32'(c);
        e.a    = 8'(a);
        e.b    = 8'(b);
        return e;
    endfunction

    always @(negedge clk) begin
        if (valid) obs_q.push_back(mk(0, cyc, int'(period), int'(high_time)));
        if (timeout) obs_q.push_back(mk(1, cyc, int'(stuck_high), 0));
    end

    // A rise ends the previous pulse (valid if it completed) and starts a new measurement
    // that either completes within MAXC cycles or times out MAXC cycles after the rise.
    task automatic model_rise(int h, int l);
        int t = cyc;
        if (pending) exp_q.push_back(mk(0, t + LAT, prev_p, prev_h));
        if (h + l > MAXC) begin
            exp_q.push_back(mk(1, t + LAT + MAXC, int'(h > MAXC), 0));
            pending = 1'b0;
        end else begin
            pending = 1'b1;
            prev_p  = h + l;
            prev_h  = h;
        end
    endtask

    task automatic drain();
        ev_t e, o;
        while (exp_q.size() > 0 && int'(exp_q[0].cyc) <= cyc) begin
            e = exp_q.pop_front();
            if (e.kind == 2'd0) begin
                mp = e.a;
                mh = e.b;
            end else ms = e.a[0];
            o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
            total++;
            assert (o === e) else begin
                bad++;
                $error("FAIL event got kind=%0d cyc=%0d a=%0d b=%0d want kind=%0d cyc=%0d a=%0d b=%0d",
                       o.kind, o.cyc, o.a, o.b, e.kind, e.cyc, e.a, e.b);
            end
        end
        total++;
        assert (obs_q.size() === 0) else begin
            bad++;
            $error("FAIL extra_events got=%0d want=0 first kind=%0d cyc=%0d", obs_q.size(), obs_q[0].kind, obs_q[0].cyc);
            obs_q.delete();
        end
        total++;
        assert ({period, high_time, stuck_high} === {mp, mh, ms}) else begin
            bad++;
            $error("FAIL outputs got p=%0d h=%0d sh=%0d want p=%0d h=%0d sh=%0d",
                   period, high_time, stuck_high, mp, mh, ms);
        end
    endtask

    task automatic pulse(int h, int l);
        pwm_in = 1'b1;
        model_rise(h, l);
        repeat (h) @(negedge clk);
        #1 pwm_in = 1'b0;
        repeat (l) @(negedge clk);
        #1 drain();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        total++;
        assert ({period, high_time, valid, timeout, stuck_high} === '0) else begin
            bad++;
            $error("FAIL reset_state got=%h want=0", {period, high_time, valid, timeout, stuck_high});
        end
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        repeat (5) pulse(25, 75);
        repeat (4) pulse(30, 10);
        for (int i = 0; i < 25; i++) pulse($urandom_range(1, 120), $urandom_range(1, 120));
        pulse(1, 1);
        pulse(1, 3);
        pulse(10, 245);
        pulse(10, 246);
        pulse(20, 400);
        pulse(300, 60);
        repeat (3) pulse(50, 10);
        pulse(40, 20);
        pwm_in = 1'b1;
        model_rise(10, 5);
        repeat (10) @(negedge clk);
        #1 drain();
        #2 rst_n = 1'b0;
        pwm_in = 1'b0;
        #1;
        total++;
        assert ({period, high_time, valid, timeout, stuck_high} === '0) else begin
            bad++;
            $error("FAIL async_reset got=%h want=0", {period, high_time, valid, timeout, stuck_high});
        end
        pending = 1'b0;
        mp = '0;
        mh = '0;
        ms = 1'b0;
        exp_q.delete();
        obs_q.delete();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        repeat (3) pulse(30, 20);
        for (int i = 0; i < 5; i++) pulse($urandom_range(1, 60), $urandom_range(1, 60));
        pulse(5, 5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
